// File: rtl/dma_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dma_wb_pkg
//  Purpose  : Shared definitions for the DMA Wishbone memory responder.
//             It holds the bus widths, the wait-state counter width, the
//             responder FSM encoding and an address-decode helper.
//  Revision : 1.0  initial release
// ============================================================================
package dma_wb_pkg;

  localparam int ADDR_W = 16;   // word address width on the DMA bus
  localparam int DATA_W = 32;   // data width on the DMA bus
  localparam int WAIT_W = 4;    // programmable wait states 0..15

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // waiting for cyc & stb
    ST_WAIT = 2'd1,   // counting down inserted wait states
    ST_ACK  = 2'd2    // one-cycle acknowledge
  } state_e;

  // The offset is an unsigned 16-bit difference, so an address below BASE
  // wraps to a large value and is rejected here as well.
  function automatic logic offset_in_range(input logic [ADDR_W-1:0] off,
                                           input int                aw);
    return ((off >> aw) == '0);
  endfunction

endpackage : dma_wb_pkg
`default_nettype wire

// File: rtl/sp_ram.sv
`default_nettype none
// ============================================================================
//  Module   : sp_ram
//  Purpose  : Single-port word RAM with a synchronous write and a
//             synchronous, registered read. The read register only updates
//             on an enabled read, so it holds the last word read. The
//             contents and the read register are not reset.
//  Ports    : clk      - clock
//             i_en     - access enable
//             i_we     - 1 = write i_wdata, 0 = read into o_rdata
//             i_addr   - word address (AW bits)
//             i_wdata  - write data (DW bits)
//             o_rdata  - registered read data (DW bits)
//  Revision : 1.0  initial release
// ============================================================================
module sp_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(2**AW)-1];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule : sp_ram
`default_nettype wire

// File: rtl/dma_wb_resp.sv
`default_nettype none
// ============================================================================
//  Module   : dma_wb_resp
//  Purpose  : Wishbone-style slave memory responder at the target end of the
//             hub DMA master port. It completes single-beat reads and writes
//             against an on-chip word RAM after a programmable number of wait
//             states. It also keeps a saturating count of in-range writes and
//             a sticky out-of-range error flag.
//  Ports    : clk, rst       - clock, synchronous active-high reset
//             wb_cyc_i       - bus cycle valid (dropping it aborts a WAIT)
//             wb_stb_i       - request strobe
//             wb_we_i        - 1 = write, 0 = read
//             wb_addr_i      - 16-bit word address
//             wb_data_i      - write data
//             wb_ack_o       - one-cycle transfer acknowledge
//             wb_data_o      - read data, valid while wb_ack_o is high
//             wait_cycles_i  - wait states before ack, sampled at capture
//             clr_i          - clears wr_count_o and err_o
//             wr_count_o     - acked in-range writes, saturating
//             err_o          - sticky, set by an acked out-of-range access
//  Revision : 1.0  initial release
// ============================================================================
module dma_wb_resp
  import dma_wb_pkg::*;
#(
  parameter int                AW   = 8,
  parameter int                DW   = DATA_W,
  parameter logic [ADDR_W-1:0] BASE = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DW-1:0]     wb_data_i,
  output logic              wb_ack_o,
  output logic [DW-1:0]     wb_data_o,
  input  logic [WAIT_W-1:0] wait_cycles_i,
  input  logic              clr_i,
  output logic [15:0]       wr_count_o,
  output logic              err_o
);

  // FSM and captured request
  state_e              r_state;
  state_e              w_state_nxt;
  logic [WAIT_W-1:0]   r_cnt;
  logic [WAIT_W-1:0]   w_cnt_nxt;
  logic                w_capture;
  logic                w_enter_ack;

  logic                r_we;
  logic [ADDR_W-1:0]   r_offset;
  logic [DW-1:0]       r_wdata;

  // Effective access. When ACK is entered straight from IDLE (zero wait
  // states) the request has not been registered yet, so the live bus inputs
  // are used. In every other case the captured copy is used.
  logic [ADDR_W-1:0]   w_live_offset;
  logic [ADDR_W-1:0]   w_acc_offset;
  logic                w_acc_we;
  logic [DW-1:0]       w_acc_wdata;
  logic                w_acc_in_range;

  logic                w_ram_en;
  logic [DW-1:0]       w_ram_rdata;

  // Status
  logic [15:0]         r_wr_count;
  logic                r_err;
  logic                r_rd_zero;   // force wb_data_o to 0 (reset / OOR read)

  assign w_live_offset = wb_addr_i - BASE;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_enter_ack = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          w_capture = 1'b1;
          if (wait_cycles_i == '0) begin
            w_state_nxt = ST_ACK;
            w_enter_ack = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = wait_cycles_i;
          end
        end
      end
      ST_WAIT: begin
        // An abort wins over a same-cycle expiry of the wait count.
        if (!wb_cyc_i) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == WAIT_W'(1)) begin
          w_state_nxt = ST_ACK;
          w_enter_ack = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - WAIT_W'(1);
        end
      end
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Request capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_offset <= '0;
      r_wdata  <= '0;
    end else if (w_capture) begin
      r_we     <= wb_we_i;
      r_offset <= w_live_offset;
      r_wdata  <= wb_data_i;
    end
  end

  assign w_acc_offset   = (r_state == ST_IDLE) ? w_live_offset : r_offset;
  assign w_acc_we       = (r_state == ST_IDLE) ? wb_we_i       : r_we;
  assign w_acc_wdata    = (r_state == ST_IDLE) ? wb_data_i     : r_wdata;
  assign w_acc_in_range = offset_in_range(w_acc_offset, AW);

  // --------------------------------------------------------------------------
  // RAM: written or read on the ACK-entry edge, only for in-range offsets
  // --------------------------------------------------------------------------
  assign w_ram_en = w_enter_ack && w_acc_in_range && !rst;

  sp_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_acc_we),
    .i_addr  (w_acc_offset[AW-1:0]),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_ram_rdata)
  );

  // The RAM read register is not reset and is left untouched by an
  // out-of-range read. This flag masks it so the bus data reads 0 after
  // reset and after an out-of-range read. It keeps the last value otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_zero <= 1'b1;
    end else if (w_enter_ack && !w_acc_we) begin
      r_rd_zero <= !w_acc_in_range;
    end
  end

  // --------------------------------------------------------------------------
  // Status: clear takes priority over a same-edge increment or error set
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      r_wr_count <= '0;
      r_err      <= 1'b0;
    end else if (w_enter_ack) begin
      if (w_acc_in_range) begin
        if (w_acc_we && (r_wr_count != 16'hFFFF)) begin
          r_wr_count <= r_wr_count + 16'd1;
        end
      end else begin
        r_err <= 1'b1;
      end
    end
  end

  assign wb_ack_o   = (r_state == ST_ACK);
  assign wb_data_o  = r_rd_zero ? '0 : w_ram_rdata;
  assign wr_count_o = r_wr_count;
  assign err_o      = r_err;

endmodule : dma_wb_resp
`default_nettype wire

// File: tb/tb_dma_wb_resp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dma_wb_resp
//  Purpose  : Self-checking bench for dma_wb_resp. A transaction-level model
//             predicts ack timing, read data and status from edge arithmetic
//             (ack edge = capture edge + W). It is compared against the DUT on
//             every cycle. Directed cases pin the model with literals, and a
//             randomized phase follows.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dma_wb_resp;

  localparam int          AW   = 8;
  localparam logic [15:0] BASE = 16'h0100;

  logic        clk = 1'b0;
  logic        rst, cyc, stb, we, clr;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wt;
  logic        ack, err;
  logic [31:0] rdata;
  logic [15:0] cnt;

  always #5 clk = ~clk;

  dma_wb_resp #(.AW(AW), .DW(32), .BASE(BASE)) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_cyc_i      (cyc),
    .wb_stb_i      (stb),
    .wb_we_i       (we),
    .wb_addr_i     (addr),
    .wb_data_i     (wdata),
    .wb_ack_o      (ack),
    .wb_data_o     (rdata),
    .wait_cycles_i (wt),
    .clr_i         (clr),
    .wr_count_o    (cnt),
    .err_o         (err)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int e_n      = 0;    // rising-edge number
  bit chk_en   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, e_n);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model (transaction level)
  // --------------------------------------------------------------------------
  logic [31:0] m_mem [256];
  bit          m_vld [256];
  bit          m_pend;
  int          m_cap, m_w, m_free;
  bit          m_we;
  logic [15:0] m_off;
  logic [31:0] m_wd;
  bit          m_ack;
  logic [31:0] m_data;
  bit          m_known;
  logic [15:0] m_count;
  bit          m_err;

  always @(posedge clk) begin
    e_n++;
    m_ack = 0;
    if (rst) begin
      m_pend = 0; m_count = 16'h0; m_err = 0;
      m_data = 32'h0; m_known = 1; m_free = e_n + 1;
    end else begin
      if (m_pend && !cyc) begin          // abort anywhere before the ack
        m_pend = 0;
        m_free = e_n + 1;
      end
      if (!m_pend && e_n >= m_free && cyc && stb) begin
        m_pend = 1; m_cap = e_n; m_w = int'(wt);
        m_we = we; m_off = addr - BASE; m_wd = wdata;
      end
      if (m_pend && e_n == m_cap + m_w) begin
        m_pend = 0; m_ack = 1; m_free = e_n + 2;
        if (m_off < 16'd256) begin
          if (m_we) begin
            m_mem[m_off[7:0]] = m_wd; m_vld[m_off[7:0]] = 1;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
          end else begin
            m_data = m_mem[m_off[7:0]]; m_known = m_vld[m_off[7:0]];
          end
        end else begin
          m_err = 1;
          if (!m_we) begin m_data = 32'h0; m_known = 1; end
        end
      end
      if (clr) begin m_count = 16'h0; m_err = 0; end
    end
  end

  // Cycle-by-cycle compare
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack", {31'h0, ack}, {31'h0, m_ack});
      chk("wr_count", {16'h0, cnt}, {16'h0, m_count});
      chk("err", {31'h0, err}, {31'h0, m_err});
      if (m_known) chk("rdata", rdata, m_data);
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  // One request; lat = cycles from capture edge to the ack cycle (1 + W).
  task automatic do_req(input bit w, input logic [15:0] a, input logic [31:0] d,
                        input int W, input bit clr_same, output int lat);
    int cap;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; addr = a; wdata = d; wt = 4'(W); clr = clr_same;
    @(negedge clk);
    cap = e_n; clr = 0;
    stb = 1'($urandom_range(0, 1));
    if (W > 0) begin                 // completion must use the captured copy
      addr = 16'($urandom); wdata = $urandom; wt = 4'($urandom); we = 1'($urandom);
    end
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (ack) begin lat = e_n - cap + 1; break; end
    end
    cyc = 0; stb = 0;
    chk("ack_seen", {31'h0, lat >= 0}, 32'h1);
  endtask

  // Write request aborted by dropping cyc j+1 edges after capture (j < W).
  task automatic do_abort(input logic [15:0] a, input logic [31:0] d, input int W, input int j);
    int acks = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; addr = a; wdata = d; wt = 4'(W);
    @(negedge clk);
    stb = 0;
    repeat (j) @(negedge clk);
    cyc = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("abort_no_ack", 32'(acks), 32'h0);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  int          lat;
  int          ack_edge [4];
  logic [31:0] sdat [4];

  initial begin
    rst = 1; cyc = 0; stb = 0; we = 0; clr = 0;
    addr = 16'h0; wdata = 32'h0; wt = 4'h0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk_en = 1;
    chk("reset_ack", {31'h0, ack}, 32'h0);
    chk("reset_data", rdata, 32'h0);
    chk("reset_count", {16'h0, cnt}, 32'h0);
    chk("reset_err", {31'h0, err}, 32'h0);

    // Write, zero wait states
    do_req(1, BASE + 16'h0005, 32'hDEADBEEF, 0, 0, lat);
    chk("w0_latency", 32'(lat), 32'd1);
    @(negedge clk);
    chk("w0_count", {16'h0, cnt}, 32'd1);

    // Read with three wait states
    do_req(0, BASE + 16'h0005, 32'h0, 3, 0, lat);
    chk("w3_latency", 32'(lat), 32'd4);
    chk("w3_rdata", rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("w3_ack_width", {31'h0, ack}, 32'h0);

    // Out of range: above the window, and below BASE (wrapping offset)
    do_req(1, BASE, 32'h11111111, 1, 0, lat);
    do_req(1, 16'h0200, 32'h0BADF00D, 0, 0, lat);
    chk("oor_acked_lat", 32'(lat), 32'd1);
    @(negedge clk);
    chk("oor_err", {31'h0, err}, 32'h1);
    chk("oor_count", {16'h0, cnt}, 32'd2);
    do_req(0, BASE, 32'h0, 2, 0, lat);
    chk("oor_ram_kept", rdata, 32'h11111111);
    do_req(0, 16'h00FF, 32'h0, 0, 0, lat);
    chk("oor_read_zero", rdata, 32'h0);
    @(negedge clk); clr = 1;
    @(negedge clk); clr = 0;
    chk("clr_err", {31'h0, err}, 32'h0);
    chk("clr_count", {16'h0, cnt}, 32'h0);
    do_req(1, 16'h0300, 32'h0, 0, 1, lat);   // clear wins over error set
    @(negedge clk);
    chk("clr_prio_err", {31'h0, err}, 32'h0);

    // Abort two cycles after capture
    do_abort(BASE + 16'h0005, 32'h12345678, 5, 1);
    do_req(0, BASE + 16'h0005, 32'h0, 0, 0, lat);
    chk("abort_ram_kept", rdata, 32'hDEADBEEF);
    chk("after_abort_lat", 32'(lat), 32'd1);

    // Reset while in WAIT discards the pending write
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; addr = BASE + 16'h0005; wdata = 32'hCAFEF00D; wt = 4'd6;
    @(negedge clk); stb = 0;
    @(negedge clk);
    @(negedge clk); rst = 1; cyc = 0;
    @(negedge clk); rst = 0;
    chk("rst_wait_ack", {31'h0, ack}, 32'h0);
    chk("rst_wait_data", rdata, 32'h0);
    chk("rst_wait_count", {16'h0, cnt}, 32'h0);
    chk("rst_wait_err", {31'h0, err}, 32'h0);
    do_req(0, BASE + 16'h0005, 32'h0, 1, 0, lat);
    chk("rst_write_dropped", rdata, 32'hDEADBEEF);

    // Streaming: stb held high across acks, four writes
    for (int k = 0; k < 4; k++) sdat[k] = $urandom;
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; wt = 4'd0; addr = BASE; wdata = sdat[0];
    for (int k = 0; k < 4; k++) begin
      ack_edge[k] = -100;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (ack) begin ack_edge[k] = e_n; break; end
      end
      if (k < 3) begin addr = BASE + 16'(k + 1); wdata = sdat[k + 1]; end
      else begin cyc = 0; stb = 0; end
    end
    for (int k = 1; k < 4; k++)
      chk("stream_spacing", 32'(ack_edge[k] - ack_edge[k - 1]), 32'd2);
    @(negedge clk);
    chk("stream_count", {16'h0, cnt}, 32'd4);
    for (int k = 0; k < 4; k++) begin
      do_req(0, BASE + 16'(k), 32'h0, k, 0, lat);
      chk("stream_read", rdata, sdat[k]);
    end

    // Saturation
    @(negedge clk);
    #3;
    force dut.r_wr_count = 16'hFFFE;
    m_count = 16'hFFFE;
    #1;
    release dut.r_wr_count;
    for (int k = 0; k < 3; k++) do_req(1, BASE + 16'h0040 + 16'(k), $urandom, k, 0, lat);
    @(negedge clk);
    chk("sat_count", {16'h0, cnt}, 32'h0000FFFF);

    // Randomized phase
    for (int t = 0; t < 250; t++) begin
      logic [15:0] a;
      int          W, r;
      r = $urandom_range(0, 99);
      a = (r < 85) ? BASE + 16'($urandom_range(0, 31)) : 16'($urandom);
      W = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0 && W > 0) begin
        do_abort(a, $urandom, W, $urandom_range(0, W - 1));
      end else begin
        do_req(1'($urandom), a, $urandom, W, ($urandom_range(0, 7) == 0), lat);
        chk("rand_latency", 32'(lat), 32'(W + 1));
      end
      if ($urandom_range(0, 15) == 0) begin
        @(negedge clk); clr = 1;
        @(negedge clk); clr = 0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_dma_wb_resp
`default_nettype wire

// File: doc/dma_wb_resp.md
Name: dma_wb_resp

Overview:
- Wishbone-style slave memory responder: the target end of the hub's DMA master port (cyc/stb/ack/we/16-bit addr/32-bit data).
- Accepts single-beat DMA writes into on-chip word RAM and serves single-beat reads.
- Programmable wait states exercise the master's ack handling; write counter and sticky error flag give status visibility.
- Sits between the I/O hub DMA port and system memory; also serves as a bench model of that memory.

Parameters:
- AW, 8, RAM address width; depth = 2^AW 32-bit words.
- DW, 32, data width.
- BASE, 16'h0000, first word address decoded by this responder.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe, request present
- wb_we_i  in  1  1 = write, 0 = read
- wb_addr_i  in  16  word address
- wb_data_i  in  DW  write data
- wb_ack_o  out  1  single-cycle transfer acknowledge
- wb_data_o  out  DW  read data, valid while wb_ack_o = 1
- wait_cycles_i  in  4  extra wait states inserted before ack (0..15)
- clr_i  in  1  clears wr_count_o and err_o
- wr_count_o  out  16  completed in-range writes, saturating
- err_o  out  1  sticky: an access outside [BASE, BASE+2^AW-1] was acknowledged

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - wb_ack_o = 0, wb_data_o = 0, wr_count_o = 0, err_o = 0.
  - FSM = IDLE, wait counter = 0.
  - RAM contents are not reset.
- Request: wb_cyc_i & wb_stb_i sampled high at a rising edge while in IDLE.
  - Captures addr, we and data.
  - Computes offset = wb_addr_i - BASE, 16-bit unsigned.
  - in_range = offset < 2^AW.
- FSM states and transitions:
  - IDLE -> ACK when wait_cycles_i == 0.
  - IDLE -> WAIT otherwise; loads cnt = wait_cycles_i (value sampled at capture only).
  - WAIT: cnt decrements each cycle; -> ACK when cnt == 1.
  - WAIT -> IDLE if wb_cyc_i drops (abort): no write, no ack, no count change.
  - ACK: wb_ack_o = 1 for exactly one cycle, then -> IDLE unconditionally. ACK is not abortable.
- Latency: ack is high in cycle 1 + W after the capture edge (W = wait_cycles_i at capture). A new request is not accepted in the ACK cycle, so there is a minimum of one dead cycle between acks.
- Write:
  - RAM is written at the ACK-entry edge, only if in_range.
  - Out-of-range writes are dropped but still acked.
- Read:
  - Synchronous RAM read issued on ACK entry.
  - wb_data_o = RAM[offset] if in_range, else 0. Valid only while ack is high.
  - wb_data_o holds its last value otherwise.
- wr_count_o: +1 on each acked in-range write; saturates at 16'hFFFF.
- err_o: set on any acked out-of-range access.
- clr_i: zeroes wr_count_o and err_o. Priority over a same-cycle increment or error set (result 0).
- Master drops stb during WAIT but keeps cyc: request stays captured and ack is still issued. The captured request, not live bus inputs, governs completion.
- Reset mid-transfer (any state) returns to IDLE next edge with ack low; a pending write is discarded.
- Back-to-back: a master holding stb high across ack is re-sampled in the IDLE cycle after ACK as a new request.

Decomposition:
- Shared package dma_wb_pkg:
  - FSM state encoding (IDLE, WAIT, ACK).
  - Bus widths: ADDR_W = 16, DATA_W = 32.
  - WAIT_W = 4.
- One sub-module: sp_ram (single-port, synchronous write and read, AW/DW parameters), instantiated once.

Test Plan:
- Write, wait 0: addr 16'h0005, data 32'hDEADBEEF, W=0 -> ack one cycle after capture; wr_count_o = 1; later read of 0x0005 returns 32'hDEADBEEF with ack.
- Wait states: W=3, read of 0x0005 -> ack exactly 4 cycles after capture, single cycle wide, data 32'hDEADBEEF.
- Out of range: BASE=16'h0100, AW=8, write to 16'h0200 -> acked, RAM unchanged, err_o = 1, wr_count_o unchanged; clr_i -> err_o = 0.
- Abort: W=5, drop wb_cyc_i 2 cycles after capture -> no ack, RAM at target unchanged, FSM back to IDLE, next request serviced normally.
- Streaming: stb held high for 4 writes to 0x0000..0x0003, W=0 -> acks every other cycle, wr_count_o = 4; reads return the written data in order.
- Saturation/reset: preload wr_count_o to 16'hFFFE via writes (or force), do 3 writes -> count stops at 16'hFFFF; assert rst in WAIT -> ack never issued, all outputs 0 next cycle.
